// File: rtl/multicycle_cpu.sv
// Multicycle accumulator-style CPU core with a single shared memory port.
// Each instruction walks FETCH_ADDR -> FETCH_WAIT -> DECODE and then either
// branches back to fetch, waits on an operand read, or waits on a write.
// All bus outputs are registered so they stay stable while Mem_EN is high.
module multicycle_cpu #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int REG_AW   = 4,
    parameter int RESET_PC = 20
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] MAR,
    input  logic [DATA_W-1:0] MBR_in,
    output logic [DATA_W-1:0] MBR_out,
    output logic              Mem_EN,
    output logic              Mem_CS,
    input  logic              Mem_RDY,
    output logic              carry,
    output logic              halted,
    output logic              illegal_op
);

    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h7;
    localparam logic [3:0] OP_SUB   = 4'h8;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_JZ    = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        FETCH_ADDR,
        FETCH_WAIT,
        DECODE,
        OPND_WAIT,
        EXECUTE,
        WRITE_WAIT,
        HALT,
        ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mbr_out_q, mbr_out_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_cs_q, mem_cs_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;

    logic [DATA_W-1:0]   rf_q [2**REG_AW];
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   rf_rdata;

    logic [3:0]          ir_op;
    logic [REG_AW-1:0]   ir_r;
    logic [ADDR_W-1:0]   ir_addr;
    logic                mem_rdy;
    logic [DATA_W:0]     add_sum;

    // Instruction fields are always taken from the latched IR.
    assign ir_op    = ir_q[DATA_W-1 -: 4];
    assign ir_r     = ir_q[DATA_W-5 -: REG_AW];
    assign ir_addr  = ir_q[ADDR_W-1:0];
    assign rf_rdata = rf_q[ir_r];

    // A completion strobe only counts while a request is outstanding.
    assign mem_rdy  = Mem_RDY & mem_en_q;
    assign add_sum  = {1'b0, rf_rdata} + {1'b0, opnd_q};

    // Next-state and datapath control for every FSM state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        mbr_out_d = mbr_out_q;
        mem_en_d  = mem_en_q;
        mem_cs_d  = mem_cs_q;
        carry_d   = carry_q;
        opnd_d    = opnd_q;
        rf_we     = 1'b0;
        rf_wdata  = opnd_q;

        case (state_q)
            FETCH_ADDR: begin
                mar_d    = pc_q;
                mem_en_d = 1'b1;
                mem_cs_d = 1'b0;
                state_d  = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_rdy) begin
                    ir_d     = MBR_in;
                    pc_d     = pc_q + ADDR_W'(1);
                    mem_en_d = 1'b0;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                mar_d = ir_addr;
                case (ir_op)
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        mem_en_d = 1'b1;
                        mem_cs_d = 1'b0;
                        state_d  = OPND_WAIT;
                    end
                    OP_STORE: begin
                        mbr_out_d = rf_rdata;
                        mem_en_d  = 1'b1;
                        mem_cs_d  = 1'b1;
                        state_d   = WRITE_WAIT;
                    end
                    OP_JMP: begin
                        pc_d    = ir_addr;
                        state_d = FETCH_ADDR;
                    end
                    OP_JZ: begin
                        if (rf_rdata == '0) begin
                            pc_d = ir_addr;
                        end
                        state_d = FETCH_ADDR;
                    end
                    OP_HALT: begin
                        state_d = HALT;
                    end
                    default: begin
                        state_d = ERROR;
                    end
                endcase
            end
            OPND_WAIT: begin
                if (mem_rdy) begin
                    opnd_d   = MBR_in;
                    mem_en_d = 1'b0;
                    state_d  = EXECUTE;
                end
            end
            EXECUTE: begin
                case (ir_op)
                    OP_LOAD: begin
                        rf_we    = 1'b1;
                        rf_wdata = opnd_q;
                    end
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = add_sum[DATA_W-1:0];
                        carry_d  = add_sum[DATA_W];
                    end
                    OP_SUB: begin
                        rf_we    = 1'b1;
                        rf_wdata = rf_rdata - opnd_q;
                        carry_d  = (rf_rdata < opnd_q);
                    end
                    default: begin
                        rf_we = 1'b0;
                    end
                endcase
                state_d = FETCH_ADDR;
            end
            WRITE_WAIT: begin
                if (mem_rdy) begin
                    mem_en_d = 1'b0;
                    state_d  = FETCH_ADDR;
                end
            end
            HALT, ERROR: begin
                mem_en_d = 1'b0;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // Control and bus registers; reset wins over any state or pending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_ADDR;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= '0;
            mar_q     <= '0;
            mbr_out_q <= '0;
            mem_en_q  <= 1'b0;
            mem_cs_q  <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mbr_out_q <= mbr_out_d;
            mem_en_q  <= mem_en_d;
            mem_cs_q  <= mem_cs_d;
            carry_q   <= carry_d;
        end
    end

    // Operand latch; pure data, no reset needed.
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
    end

    // Register file keeps its contents through reset; single write port.
    always_ff @(posedge clk) begin
        if (rf_we && !rst) begin
            rf_q[ir_r] <= rf_wdata;
        end
    end

    assign MAR        = mar_q;
    assign MBR_out    = mbr_out_q;
    assign Mem_EN     = mem_en_q;
    assign Mem_CS     = mem_cs_q;
    assign carry      = carry_q;
    assign halted     = (state_q == HALT);
    assign illegal_op = (state_q == ERROR);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: behavioural memory with per-address wait states,
// and a scoreboard of expected bus requests (reads and writes in order).
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  MAR;
    logic [15:0] MBR_in;
    logic [15:0] MBR_out;
    logic        Mem_EN;
    logic        Mem_CS;
    logic        Mem_RDY;
    logic        carry;
    logic        halted;
    logic        illegal_op;

    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic [15:0] mem [256];
    logic [7:0]  busy_cnt = 8'd0;
    logic [7:0]  ws_addr = 8'h00;
    logic [7:0]  ws_n = 8'd0;
    logic        en_prev = 1'b0;
    int          wr_cnt = 0;
    int          cyc = 0;
    int          req_cyc [256];
    logic [31:0] exp_q [$];

    logic [15:0] r1_exp;
    logic [16:0] add2;

    multicycle_cpu dut (
        .clk        (clk),
        .rst        (rst),
        .MAR        (MAR),
        .MBR_in     (MBR_in),
        .MBR_out    (MBR_out),
        .Mem_EN     (Mem_EN),
        .Mem_CS     (Mem_CS),
        .Mem_RDY    (Mem_RDY),
        .carry      (carry),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time request-to-request instruction latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Count cycles an access has been outstanding; drives wait states.
    always @(posedge clk) busy_cnt <= Mem_EN ? busy_cnt + 8'd1 : 8'd0;

    assign MBR_in  = mem[MAR];
    assign Mem_RDY = Mem_EN && (busy_cnt >= ((MAR == ws_addr) ? ws_n : 8'd0));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [7:0] a);
        return {8'h00, a, 16'h0000};
    endfunction

    function automatic logic [31:0] wr(input logic [7:0] a, input logic [15:0] d);
        return {8'h01, a, d};
    endfunction

    // Bus monitor: every new request is matched against the scoreboard.
    always @(negedge clk) begin
        if (Mem_EN && !en_prev) begin
            if (exp_q.size() == 0)
                check_val("bus_unexpected", {7'b0, Mem_CS, MAR, Mem_CS ? MBR_out : 16'h0}, 32'hFFFF_FFFF);
            else
                check_val("bus_req", {7'b0, Mem_CS, MAR, Mem_CS ? MBR_out : 16'h0}, exp_q.pop_front());
            req_cyc[MAR] <= cyc;
        end
        if (Mem_EN && Mem_CS && Mem_RDY) wr_cnt <= wr_cnt + 1;
        en_prev <= Mem_EN;
    end

    task automatic wait_req(input logic [7:0] a);
        int n = 0;
        while (!(Mem_EN && !Mem_CS && MAR == a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("reach_fetch_%0h", a), {31'b0, n < 100}, 32'h1);
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_halt", {31'b0, n < 100}, 32'h1);
    endtask

    task automatic wait_illegal();
        int n = 0;
        while (!illegal_op && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_error", {31'b0, n < 100}, 32'h1);
    endtask

    task automatic wait_write_req();
        int n = 0;
        while (!(Mem_EN && Mem_CS) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_write", {31'b0, n < 100}, 32'h1);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Boot vector jumps to the program; it becomes data once fetched.
        mem[8'h14] = 16'hC020;
        mem[8'h15] = 16'h0007;
        mem[8'h17] = 16'hFFFF;
        mem[8'h18] = 16'h0001;
        mem[8'h20] = 16'h3114;   // LOAD  R1,[14]
        mem[8'h21] = 16'h7115;   // ADD   R1,[15]
        mem[8'h22] = 16'hB116;   // STORE R1,[16]
        mem[8'h23] = 16'h3217;   // LOAD  R2,[17]
        mem[8'h24] = 16'h7218;   // ADD   R2,[18]
        mem[8'h25] = 16'hD230;   // JZ    R2,30
        mem[8'h30] = 16'hB219;   // STORE R2,[19]
        mem[8'h31] = 16'hD133;   // JZ    R1,33 (not taken)
        mem[8'h32] = 16'hC040;   // JMP   40
        mem[8'h40] = 16'hC041;   // JMP   41
        mem[8'h41] = 16'hC0FF;   // JMP   FF (fetched with 3 wait states)
        mem[8'hFF] = 16'hB11A;   // STORE R1,[1A]; PC wraps to 00
        mem[8'h00] = 16'hF000;   // HALT
        ws_addr = 8'h41;
        ws_n    = 8'd3;

        r1_exp = 16'd5 + 16'd7;
        add2   = {1'b0, 16'hFFFF} + {1'b0, 16'h0001};

        repeat (3) @(negedge clk);
        check_val("rst_MAR",     32'(MAR),        32'h0);
        check_val("rst_MEM_EN",  32'(Mem_EN),     32'h0);
        check_val("rst_MEM_CS",  32'(Mem_CS),     32'h0);
        check_val("rst_MBR_OUT", 32'(MBR_out),    32'h0);
        check_val("rst_CARRY",   32'(carry),      32'h0);
        check_val("rst_HALTED",  32'(halted),     32'h0);
        check_val("rst_ILLEGAL", 32'(illegal_op), 32'h0);

        exp_q.push_back(rd(8'h14));
        exp_q.push_back(rd(8'h20));
        exp_q.push_back(rd(8'h14));
        exp_q.push_back(rd(8'h21));
        exp_q.push_back(rd(8'h15));
        exp_q.push_back(rd(8'h22));
        exp_q.push_back(wr(8'h16, r1_exp));
        exp_q.push_back(rd(8'h23));
        exp_q.push_back(rd(8'h17));
        exp_q.push_back(rd(8'h24));
        exp_q.push_back(rd(8'h18));
        exp_q.push_back(rd(8'h25));
        exp_q.push_back(rd(8'h30));
        exp_q.push_back(wr(8'h19, add2[15:0]));
        exp_q.push_back(rd(8'h31));
        exp_q.push_back(rd(8'h32));
        exp_q.push_back(rd(8'h40));
        exp_q.push_back(rd(8'h41));
        exp_q.push_back(rd(8'hFF));
        exp_q.push_back(wr(8'h1A, r1_exp));
        exp_q.push_back(rd(8'h00));
        rst = 1'b0;

        wait_req(8'h20);
        mem[8'h14] = 16'h0005;

        wait_req(8'h22);
        check_val("carry_after_add", 32'(carry), 32'h0);
        wait_req(8'h25);
        check_val("carry_add_ovf", 32'(carry), 32'(add2[16]));

        wait_req(8'h41);
        for (int k = 0; k < 4; k++) begin
            check_val("wait_mem_en", 32'(Mem_EN), 32'h1);
            check_val("wait_mar",    32'(MAR),    32'h41);
            @(negedge clk);
        end

        wait_halt();
        repeat (4) begin
            @(negedge clk);
            check_val("halt_sticky", 32'(halted), 32'h1);
            check_val("halt_mem_en", 32'(Mem_EN), 32'h0);
        end
        check_val("carry_kept", 32'(carry), 32'(add2[16]));
        check_val("lat_load",   32'(req_cyc[8'h21] - req_cyc[8'h20]), 32'd5);
        check_val("lat_add",    32'(req_cyc[8'h22] - req_cyc[8'h21]), 32'd5);
        check_val("lat_store",  32'(req_cyc[8'h23] - req_cyc[8'h22]), 32'd4);
        check_val("lat_jz",     32'(req_cyc[8'h30] - req_cyc[8'h25]), 32'd3);
        check_val("lat_jz_nt",  32'(req_cyc[8'h32] - req_cyc[8'h31]), 32'd3);
        check_val("lat_jmp",    32'(req_cyc[8'h41] - req_cyc[8'h40]), 32'd3);
        check_val("lat_jmp_ws", 32'(req_cyc[8'hFF] - req_cyc[8'h41]), 32'd6);
        check_val("writes_a",   32'(wr_cnt), 32'd3);

        // Reset lands on mem[14], which now holds data 0005: opcode 0.
        exp_q.push_back(rd(8'h14));
        pulse_rst();
        wait_illegal();
        repeat (3) begin
            @(negedge clk);
            check_val("err_sticky", 32'(illegal_op), 32'h1);
            check_val("err_mem_en", 32'(Mem_EN),     32'h0);
            check_val("err_halted", 32'(halted),     32'h0);
        end
        check_val("err_carry_rst", 32'(carry), 32'h0);
        exp_q.push_back(rd(8'h14));
        pulse_rst();
        wait_req(8'h14);
        wait_illegal();

        // Store that never completes, abandoned by reset.
        mem[8'h14] = 16'hC060;
        mem[8'h60] = 16'hB11B;
        ws_addr    = 8'h1B;
        ws_n       = 8'd200;
        exp_q.push_back(rd(8'h14));
        exp_q.push_back(rd(8'h60));
        exp_q.push_back(wr(8'h1B, r1_exp));
        pulse_rst();
        wait_write_req();
        repeat (2) begin
            @(negedge clk);
            check_val("ww_mem_en",  32'(Mem_EN),  32'h1);
            check_val("ww_mem_cs",  32'(Mem_CS),  32'h1);
            check_val("ww_mbr_out", 32'(MBR_out), 32'(r1_exp));
            check_val("ww_mar",     32'(MAR),     32'h1B);
        end
        rst = 1'b1;
        mem[8'h14] = 16'hF000;
        exp_q.push_back(rd(8'h14));
        @(negedge clk);
        check_val("abort_mem_en", 32'(Mem_EN), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_req(8'h14);
        wait_halt();
        repeat (3) @(negedge clk);
        check_val("writes_final", 32'(wr_cnt),       32'd3);
        check_val("sb_drained",   32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
